// File: rtl/mem_stage_bus.sv
// mem_stage_bus: MEM pipeline stage driving a req/ack data bus.
// Runs LB/LW/SB/SW as a two-state IDLE/BUSY FSM and stalls IF/ID/EX while a
// transfer is outstanding; non-memory ops pass straight to the WB registers.
// Optional macro MEM_TIMEOUT_EN: abandon a transfer after TIMEOUT_CYCLES
// un-acked BUSY cycles, pulse err_o and write 0 for loads.
module mem_stage_bus #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [4:0]  waddr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_req_o,
  output logic [4:0]  waddr_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  output logic        err_o
);

  localparam logic [7:0] EXE_LB_OP = 8'b1110_0000;
  localparam logic [7:0] EXE_LW_OP = 8'b1110_0011;
  localparam logic [7:0] EXE_SB_OP = 8'b1110_1000;
  localparam logic [7:0] EXE_SW_OP = 8'b1110_1011;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state_reg;
  logic        lb_reg;     // outstanding load is a byte load
  logic [1:0]  lane_reg;   // byte lane of the outstanding access
  logic        is_mem;
  logic        is_store;
  logic        is_byte;
  logic        timeout_hit;
  logic        done;
  logic [31:0] rdata_eff;
  logic [7:0]  rbyte;
  logic [31:0] load_result;

  assign is_store = (aluop_i == EXE_SB_OP) || (aluop_i == EXE_SW_OP);
  assign is_byte  = (aluop_i == EXE_SB_OP) || (aluop_i == EXE_LB_OP);
  assign is_mem   = is_store || (aluop_i == EXE_LB_OP) || (aluop_i == EXE_LW_OP);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_reg;

  assign timeout_hit = (state_reg == BUSY) && (cnt_reg == 8'(TIMEOUT_CYCLES));

  // Count un-acked BUSY cycles; cleared whenever a transfer is issued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= 8'd0;
    end else if (state_reg == IDLE) begin
      cnt_reg <= 8'd0;
    end else if (!bus_ack_i && !timeout_hit) begin
      cnt_reg <= cnt_reg + 8'd1;
    end
  end

  // One-cycle error pulse when a transfer is abandoned (a real ack wins)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_o <= 1'b0;
    end else begin
      err_o <= timeout_hit && bus_req_o && !bus_ack_i;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign err_o              = 1'b0;
`endif

  // A transfer completes on a real ack or on timeout expiry; ack only counts while requesting
  assign done        = (state_reg == BUSY) && bus_req_o && (bus_ack_i || timeout_hit);
  assign stall_req_o = is_mem && !done;

  // Expired transfers read as zero; byte loads pick their lane and sign-extend
  assign rdata_eff   = bus_ack_i ? bus_rdata_i : 32'd0;
  assign rbyte       = rdata_eff[8*lane_reg +: 8];
  assign load_result = lb_reg ? {{24{rbyte[7]}}, rbyte} : rdata_eff;

  // FSM, bus request registers and the MEM->WB boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      lb_reg      <= 1'b0;
      lane_reg    <= 2'd0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_be_o    <= 4'd0;
      bus_wdata_o <= 32'd0;
      waddr_o     <= 5'd0;
      we_o        <= 1'b0;
      wdata_o     <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_mem) begin
            state_reg   <= BUSY;
            bus_req_o   <= 1'b1;
            bus_we_o    <= is_store;
            bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            bus_be_o    <= is_byte ? (4'b0001 << mem_addr_i[1:0]) : 4'hF;
            bus_wdata_o <= !is_store ? 32'd0 :
                           is_byte   ? {4{mem_data_i[7:0]}} : mem_data_i;
            lb_reg      <= (aluop_i == EXE_LB_OP);
            lane_reg    <= mem_addr_i[1:0];
            we_o        <= 1'b0;
          end else begin
            waddr_o <= waddr_i;
            we_o    <= we_i;
            wdata_o <= wdata_i;
          end
        end
        BUSY: begin
          if (done) begin
            state_reg <= IDLE;
            bus_req_o <= 1'b0;
            if (!bus_we_o) begin
              we_o    <= we_i;
              waddr_o <= waddr_i;
              wdata_o <= load_result;
            end else begin
              we_o <= 1'b0;
            end
          end else begin
            we_o <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
